rs232_rx_frontend: RTL and testbench

Serial receive front end for the Nios RS-232 path. It oversamples the asynchronous `rxd` line at 16x the selected baud rate and deframes 8-bit characters with optional parity. Each character, with its parity-error flag, is presented to the Nios `rs232_rx` / `rx_parity` PIO inputs. A valid/acknowledge handshake runs against the `rx_read` in/out ports. Baud rate and parity mode come from the Nios `rx_options` PIO output.

---
 rtl/rs232_rx_frontend.sv | 180 ++++++++++++++++++
 tb/tb_rs232_rx_frontend.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_frontend.sv
// RS-232 receive front end: 16x oversampled deframer (8 data bits, optional parity)
// with a single-entry valid/ack output register and sticky overrun.
module rs232_rx_frontend #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       rxd,
    input  logic [7:0] rx_options,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);
    localparam int DATA_W    = 8;
    localparam int DIV_9600  = CLK_FREQ / (16 * 9600);
    localparam int DIV_19200 = CLK_FREQ / (16 * 19200);
    localparam int DIV_38400 = CLK_FREQ / (16 * 38400);
    localparam int DIV_57600 = CLK_FREQ / (16 * 57600);
    localparam int DIV_115K  = CLK_FREQ / (16 * 115200);
    localparam int CNT_W     = $clog2(DIV_9600 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state;
    logic                rxd_meta;
    logic                rxs;
    logic [CNT_W-1:0]    tick_cnt;
    logic [CNT_W-1:0]    div_m1;
    logic [3:0]          samp_cnt;
    logic [2:0]          bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic [1:0]          par_mode;
    logic                par_err_r;
    logic                tick;
    logic                mid_bit;
    logic                par_en;
    logic                unused_opts;

    assign unused_opts = ^rx_options[7:5];
    assign tick        = (tick_cnt == div_m1);
    assign mid_bit     = tick && (samp_cnt == 4'd15);
    assign par_en      = ^par_mode;

    function automatic logic [CNT_W-1:0] div_minus1(input logic [2:0] sel);
        case (sel)
            3'd1:    return CNT_W'(DIV_19200 - 1);
            3'd2:    return CNT_W'(DIV_38400 - 1);
            3'd3:    return CNT_W'(DIV_57600 - 1);
            3'd4:    return CNT_W'(DIV_115K - 1);
            default: return CNT_W'(DIV_9600 - 1);
        endcase
    endfunction

    // mode 01 = even, 10 = odd; caller only uses the result when parity is enabled
    function automatic logic parity_error(input logic [1:0] mode,
                                          input logic [DATA_W-1:0] data,
                                          input logic pbit);
        logic x;
        x = ^data ^ pbit;
        return (mode == 2'b10) ? ~x : x;
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= S_IDLE;
            tick_cnt      <= '0;
            div_m1        <= '0;
            samp_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            par_mode      <= '0;
            par_err_r     <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            if (state == S_IDLE || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            // A delivery in the same cycle overrides this clear of rx_valid below
            if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        div_m1    <= div_minus1(rx_options[2:0]);
                        par_mode  <= rx_options[4:3];
                        par_err_r <= 1'b0;
                        samp_cnt  <= '0;
                        state     <= S_START;
                        rx_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (samp_cnt == 4'd7) begin
                            samp_cnt <= '0;
                            bit_cnt  <= '0;
                            if (rxs) begin
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick)
                        samp_cnt <= samp_cnt + 4'd1;
                    if (mid_bit) begin
                        shift   <= {rxs, shift[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (tick)
                        samp_cnt <= samp_cnt + 4'd1;
                    if (mid_bit) begin
                        par_err_r <= parity_error(par_mode, shift, rxs);
                        state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick)
                        samp_cnt <= samp_cnt + 4'd1;
                    if (mid_bit) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                        if (!rx_valid || rx_ack) begin
                            rx_data       <= shift;
                            rx_parity_err <= par_en & par_err_r;
                            rx_frame_err  <= ~rxs;
                            rx_valid      <= 1'b1;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_rx_frontend.sv
// Bench for rs232_rx_frontend: directed frames, a frame-level model of the
// output register checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_rs232_rx_frontend;
    localparam int DIV_FAST = 27;   // 50 MHz / (16 * 115200), floored
    localparam int DIV_SLOW = 325;  // 50 MHz / (16 * 9600), floored

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_options = 8'h04;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_parity_err, rx_valid, rx_frame_err, rx_overrun, rx_busy;

    always #5 clk = ~clk;

    rs232_rx_frontend #(.CLK_FREQ(50000000)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .rxd           (rxd),
        .rx_options    (rx_options),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    typedef struct {
        int         edge_no;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } del_t;

    del_t       dq[$];
    del_t       cur;
    int         cyc = 0;
    int         last_del = -100;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    bit         near;
    int         lat;
    int         g0;

    // Frame-level model: a byte lands at its predicted STOP edge, ack consumes it
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            m_data = 8'h00; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            dq.delete();
        end else if (dq.size() > 0 && dq[0].edge_no == cyc) begin
            cur = dq.pop_front();
            last_del = cyc;
            if (rx_ack && m_valid) m_ovr = 1'b0;
            if (!m_valid || rx_ack) begin
                m_data = cur.data; m_perr = cur.perr; m_ferr = cur.ferr; m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (rx_ack && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            near = (cyc - last_del <= 2);
            foreach (dq[i])
                if (dq[i].edge_no - cyc <= 2 && cyc - dq[i].edge_no <= 2) near = 1'b1;
            if (!near) begin
                checks = checks + 1;
                if ({rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun} !==
                    {m_data, m_valid, m_perr, m_ferr, m_ovr}) begin
                    failures = failures + 1;
                    $display("FAIL model_cmp cyc=%0d got d=%h v=%b pe=%b fe=%b ov=%b want d=%h v=%b pe=%b fe=%b ov=%b",
                             cyc, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun,
                             m_data, m_valid, m_perr, m_ferr, m_ovr);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks = checks + 1;
        if (act !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        wait_cyc(1);
        rx_ack = 1'b0;
    endtask

    // Drives one frame and queues what the receiver must deliver at its STOP mid-bit
    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit odd,
                              input bit pbit, input bit stopb, input bit ack_stop,
                              input int div);
        int   fall;
        int   dedge;
        bit   x;
        del_t e;
        @(posedge clk); #1;
        rxd   = 1'b0;
        fall  = cyc;
        dedge = fall + 3 + (par_en ? 168 : 152) * div;
        x     = ^d ^ pbit;
        e.edge_no = dedge;
        e.data    = d;
        e.perr    = par_en ? (odd ? (x != 1'b1) : (x != 1'b0)) : 1'b0;
        e.ferr    = ~stopb;
        dq.push_back(e);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(16 * div);
            rxd = d[i];
        end
        if (par_en) begin
            wait_cyc(16 * div);
            rxd = pbit;
        end
        wait_cyc(16 * div);
        rxd = stopb;
        while (cyc < dedge - 1) wait_cyc(1);
        if (ack_stop) rx_ack = 1'b1;
        wait_cyc(1);
        rx_ack = 1'b0;
        rxd    = 1'b1;
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_perr", rx_parity_err, 1'b0);
        chk("reset_ferr", rx_frame_err, 1'b0);
        chk("reset_ovr", rx_overrun, 1'b0);
        chk("reset_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        wait_cyc(5);

        rx_options = 8'h04;
        send_frame(8'hA5, 0, 0, 0, 1, 0, DIV_FAST);
        chk("basic_data", rx_data, 8'hA5);
        chk("basic_valid", rx_valid, 1'b1);
        chk("basic_perr", rx_parity_err, 1'b0);
        chk("basic_ferr", rx_frame_err, 1'b0);
        do_ack();
        chk("basic_ack_clear", rx_valid, 1'b0);
        wait_cyc(10);

        rx_options = 8'h0C;
        send_frame(8'h03, 1, 0, 0, 1, 0, DIV_FAST);
        chk("even_ok_data", rx_data, 8'h03);
        chk("even_ok_perr", rx_parity_err, 1'b0);
        do_ack();
        wait_cyc(10);
        send_frame(8'h03, 1, 0, 1, 1, 0, DIV_FAST);
        chk("even_bad_perr", rx_parity_err, 1'b1);
        do_ack();
        wait_cyc(10);
        rx_options = 8'h14;
        send_frame(8'h03, 1, 1, 1, 1, 0, DIV_FAST);
        chk("odd_ok_perr", rx_parity_err, 1'b0);
        do_ack();
        wait_cyc(10);

        rx_options = 8'h04;
        rxd = 1'b0;
        g0  = cyc;
        wait_cyc(10);
        chk("glitch_busy_high", rx_busy, 1'b1);
        wait_cyc(90);
        rxd = 1'b1;
        while (cyc < g0 + 431) wait_cyc(1);
        chk("glitch_busy_low", rx_busy, 1'b0);
        chk("glitch_no_valid", rx_valid, 1'b0);
        wait_cyc(10);

        send_frame(8'h5A, 0, 0, 0, 0, 0, DIV_FAST);
        chk("frame_data", rx_data, 8'h5A);
        chk("frame_ferr", rx_frame_err, 1'b1);
        wait_cyc(16 * DIV_FAST);

        send_frame(8'h22, 0, 0, 0, 1, 1, DIV_FAST);
        chk("ackstop_data", rx_data, 8'h22);
        chk("ackstop_valid", rx_valid, 1'b1);
        chk("ackstop_ovr", rx_overrun, 1'b0);
        chk("ackstop_ferr", rx_frame_err, 1'b0);
        do_ack();
        wait_cyc(10);

        send_frame(8'h11, 0, 0, 0, 1, 0, DIV_FAST);
        wait_cyc(10);
        send_frame(8'h22, 0, 0, 0, 1, 0, DIV_FAST);
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_flag", rx_overrun, 1'b1);
        chk("ovr_valid", rx_valid, 1'b1);
        do_ack();
        chk("ovr_ack_valid", rx_valid, 1'b0);
        chk("ovr_ack_clear", rx_overrun, 1'b0);
        wait_cyc(10);

        rx_options = 8'h00;
        wait_cyc(5);
        fork
            send_frame(8'h81, 0, 0, 0, 1, 0, DIV_SLOW);
            begin
                wait_cyc(16 * DIV_SLOW * 4 + 100);
                rx_options = 8'h04;
            end
            begin
                lat = 0;
                @(posedge clk); #1;
                while (!rx_valid && lat < 60000) begin
                    wait_cyc(1);
                    lat++;
                end
            end
        join
        chk("slow_latency_in_window", (lat >= 49380 && lat <= 49420), 1'b1);
        chk("slow_data", rx_data, 8'h81);
        wait_cyc(10);

        rxd = 1'b0;
        wait_cyc(16 * DIV_FAST * 5 + 100);
        rst_n = 1'b0;
        #2;
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_perr", rx_parity_err, 1'b0);
        chk("midrst_ferr", rx_frame_err, 1'b0);
        chk("midrst_ovr", rx_overrun, 1'b0);
        chk("midrst_busy", rx_busy, 1'b0);
        wait_cyc(2);
        rxd   = 1'b1;
        rst_n = 1'b1;
        wait_cyc(10);
        send_frame(8'h3C, 0, 0, 0, 1, 0, DIV_FAST);
        chk("post_rst_data", rx_data, 8'h3C);
        chk("post_rst_valid", rx_valid, 1'b1);
        chk("post_rst_ferr", rx_frame_err, 1'b0);
        do_ack();
        wait_cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
